// File: rtl/hour12_clock_pkg.sv
// hour12_clock_pkg: shared state encodings and counter limits for the 12-hour clock
package hour12_clock_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR_MIN   = 1;
  localparam int HR_MAX   = 12;
  localparam int HR_RESET = 12;
endpackage

// File: rtl/hour12_clock_ctrl_mod_n_counter.sv
// mod_n_counter: modulo-N up counter with clear, carry on terminal count while enabled
module mod_n_counter #(
  parameter int N     = 60,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             carry
);
  assign carry = en && count == WIDTH'(N - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count >= WIDTH'(N - 1) ? '0 : count + 1'b1;
endmodule

// File: rtl/hour12_clock_ctrl.sv
// hour12_clock_ctrl: 12-hour time-of-day sequencer with RUN/SET_HR/SET_MIN mode FSM
module hour12_clock_ctrl
  import hour12_clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode,
  input  logic       inc,
  output logic [3:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic [1:0] state,
  output logic       hour_tick
);
  state_t st;
  logic is_run, is_hr, is_min;
  logic sec_en, sec_carry, min_en, min_carry, hr_run, hr_set;
  logic [3:0] hr_next;
  assign is_run  = st == RUN;
  assign is_hr   = st == SET_HR;
  assign is_min  = st == SET_MIN;
  assign sec_en  = is_run && tick;
  assign min_en  = (is_run && tick && sec_carry) || (is_min && inc && !mode);
  assign hr_run  = is_run && min_carry;
  assign hr_set  = is_hr && inc && !mode;
  assign hr_next = (hours >= 4'(HR_MAX) || hours < 4'(HR_MIN)) ? 4'(HR_MIN) : hours + 4'd1;
  assign state   = st;
  mod_n_counter #(.N(SEC_MAX + 1), .WIDTH(6)) u_sec (
    .clk(clk), .reset(reset), .en(sec_en), .clr(is_min && mode), .count(seconds), .carry(sec_carry)
  );
  mod_n_counter #(.N(MIN_MAX + 1), .WIDTH(6)) u_min (
    .clk(clk), .reset(reset), .en(min_en), .clr(1'b0), .count(minutes), .carry(min_carry)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st        <= RUN;
      hours     <= 4'(HR_RESET);
      pm        <= 1'b0;
      hour_tick <= 1'b0;
    end else begin
      hour_tick <= hr_run;
      if (hr_run || hr_set) hours <= hr_next;
      if (hr_run && hours == 4'(HR_MAX - 1)) pm <= !pm;
      case (st)
        RUN:     if (mode) st <= SET_HR;
        SET_HR:  if (mode) st <= SET_MIN;
        SET_MIN: if (mode) st <= RUN;
        default: st <= RUN;
      endcase
    end
endmodule

// File: tb/tb_hour12_clock_ctrl.sv
// tb_hour12_clock_ctrl: directed self-checking bench for hour12_clock_ctrl
module tb_hour12_clock_ctrl;
  logic clk = 0, reset = 0, tick = 0, mode = 0, inc = 0;
  logic [3:0] hours;
  logic [5:0] minutes, seconds;
  logic pm, hour_tick;
  logic [1:0] state;
  int n_run = 0, n_fail = 0;
  hour12_clock_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .mode(mode), .inc(inc),
    .hours(hours), .minutes(minutes), .seconds(seconds), .pm(pm),
    .state(state), .hour_tick(hour_tick)
  );
  always #5 clk = !clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic t, input logic m, input logic i);
    @(negedge clk);
    tick = t;
    mode = m;
    inc = i;
    @(posedge clk);
    #1;
    tick = 0;
    mode = 0;
    inc = 0;
  endtask
  task automatic chk_time(input string tag, input int h, input int m, input int s, input int p);
    chk({tag, ".hours"}, int'(hours), h);
    chk({tag, ".minutes"}, int'(minutes), m);
    chk({tag, ".seconds"}, int'(seconds), s);
    chk({tag, ".pm"}, int'(pm), p);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_time("reset", 12, 0, 0, 0);
    chk("reset.state", int'(state), 0);
    chk("reset.hour_tick", int'(hour_tick), 0);
    @(negedge clk);
    reset = 1;
    step(0, 0, 0);
    chk_time("idle_after_reset", 12, 0, 0, 0);
    repeat (5) step(1, 0, 0);
    chk("tick5.seconds", int'(seconds), 5);
    step(1, 1, 0);
    chk("tick_mode.seconds", int'(seconds), 6);
    chk("tick_mode.state", int'(state), 1);
    repeat (13) step(0, 0, 1);
    chk_time("set_hr13", 1, 0, 6, 0);
    step(1, 0, 1);
    chk("tick_inc.hours", int'(hours), 2);
    chk("tick_inc.seconds", int'(seconds), 6);
    step(0, 1, 1);
    chk("mode_inc.state", int'(state), 2);
    chk("mode_inc.hours", int'(hours), 2);
    chk("mode_inc.minutes", int'(minutes), 0);
    repeat (61) step(0, 0, 1);
    chk("set_min61.minutes", int'(minutes), 1);
    chk("set_min61.hours", int'(hours), 2);
    step(0, 1, 0);
    chk("to_run.state", int'(state), 0);
    chk("to_run.seconds", int'(seconds), 0);
    step(0, 1, 0);
    repeat (9) step(0, 0, 1);
    step(0, 1, 0);
    repeat (58) step(0, 0, 1);
    step(0, 1, 0);
    repeat (58) step(1, 0, 0);
    chk_time("pre_noon", 11, 59, 58, 0);
    step(1, 0, 0);
    chk_time("pre_noon1", 11, 59, 59, 0);
    chk("pre_noon1.hour_tick", int'(hour_tick), 0);
    step(1, 0, 0);
    chk_time("noon", 12, 0, 0, 1);
    chk("noon.hour_tick", int'(hour_tick), 1);
    step(0, 0, 0);
    chk("noon_next.hour_tick", int'(hour_tick), 0);
    chk_time("noon_hold", 12, 0, 0, 1);
    repeat (3599) step(1, 0, 0);
    chk_time("pre_one", 12, 59, 59, 1);
    step(1, 0, 0);
    chk_time("one_pm", 1, 0, 0, 1);
    chk("one_pm.hour_tick", int'(hour_tick), 1);
    step(0, 0, 1);
    chk_time("inc_in_run", 1, 0, 0, 1);
    chk("inc_in_run.hour_tick", int'(hour_tick), 0);
    step(0, 1, 0);
    step(0, 1, 0);
    repeat (37) step(0, 0, 1);
    chk("set_min37.minutes", int'(minutes), 37);
    chk("set_min37.state", int'(state), 2);
    @(negedge clk);
    reset = 0;
    #1;
    chk_time("async_reset", 12, 0, 0, 0);
    chk("async_reset.state", int'(state), 0);
    @(negedge clk);
    reset = 1;
    step(0, 0, 0);
    chk_time("after_release", 12, 0, 0, 0);
    chk("after_release.state", int'(state), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/hour12_clock_ctrl.md
# hour12_clock_ctrl

Sequencer for a 12-hour time-of-day clock built from cascaded modulo counters: seconds (mod 60), minutes (mod 60) and hours (1..12 with AM/PM). A three-state mode FSM lets a user set hours and minutes from two pulse inputs. It sits between the 1 Hz enable generator and the display-decode logic.

## Interface
- No parameters. All limits are fixed constants in the shared package.

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; forces reset state immediately
- tick  in  1  one-cycle enable, nominally once per second; advances time in RUN only
- mode  in  1  one-cycle pulse, debounced externally; steps the FSM
- inc  in  1  one-cycle pulse, debounced externally; increments the field being set
- hours  out  4  current hour, 1..12, binary
- minutes  out  6  current minute, 0..59
- seconds  out  6  current second, 0..59
- pm  out  1  0 = AM, 1 = PM
- state  out  2  FSM state code: RUN=00, SET_HR=01, SET_MIN=10 (11 unused)
- hour_tick  out  1  one-cycle pulse when minutes:seconds roll 59:59 -> 00:00 in RUN

## Operation
- Reset values: hours=12, minutes=0, seconds=0, pm=0, state=RUN, hour_tick=0.
- RUN, tick=1:
  - seconds+1; at 59 wraps to 0 and carries to minutes.
  - minutes+1 on carry; at 59 wraps to 0, carries to hours and asserts hour_tick.
  - hours on carry: 11->12 toggles pm; 12->1 keeps pm; all others +1.
- RUN, tick=0: hold all counters.
- RUN, mode=1 -> SET_HR. inc ignored in RUN.
- SET_HR:
  - inc: hours+1; 12 wraps to 1; pm unchanged.
  - mode -> SET_MIN.
  - tick ignored; seconds frozen.
- SET_MIN:
  - inc: minutes+1; 59 wraps to 0; no carry into hours.
  - mode -> RUN and seconds cleared to 0 on the same edge.
  - tick ignored.
- State 11 is illegal and recovers to RUN on the next edge; counters hold.
- Simultaneous events:
  - mode and inc in a set state: mode wins; inc is dropped.
  - tick and mode in RUN: the tick is applied on that edge and state moves to SET_HR.
  - tick and inc in a set state: inc is applied; tick is dropped.
- Out-of-range counter values cannot be reached. If forced, the next increment loads the wrap value: seconds/minutes -> 0, hours -> 1.

## Timing
- All outputs are registered. An input sampled at edge N is reflected on the outputs after edge N.
- hour_tick is high for exactly the one cycle in which minutes and seconds read 0 after a rollover.
- Reset asserted mid-operation, including in a set state, forces reset values asynchronously. The first update after deassertion needs a fresh tick, mode or inc.
- Pulse inputs held high for k cycles count as k events; no edge detection is done here.

## Structure
- Package hour12_clock_pkg holds:
  - state encodings RUN, SET_HR, SET_MIN
  - SEC_MAX=59, MIN_MAX=59, HR_MIN=1, HR_MAX=12, HR_RESET=12
- Sub-module mod_n_counter (params N, WIDTH; ports en, count, carry) is instantiated for seconds and minutes.
- Hours and pm use dedicated logic because of the 1..12 range and AM/PM toggle.
- The FSM and the enable muxing (tick vs inc) live in the top module.

## Test plan
- Reset, then hold reset low for 3 cycles -> hours=12, minutes=0, seconds=0, pm=0, state=00, hour_tick=0.
- Preload 11:59:58 AM, apply 2 ticks -> 11:59:59, then 12:00:00 with pm=1; hour_tick pulses for one cycle.
- Preload 12:59:59 PM, apply 1 tick -> 1:00:00, pm=1.
- mode, then inc×13 -> state=01 and hours 12->1->...->12->1, pm unchanged. Then mode, inc×61 -> state=10, minutes=1, hours unchanged. Then mode -> state=00, seconds=0.
- In SET_HR, apply tick and inc on the same cycle -> hours+1, seconds unchanged. In RUN, apply tick and mode together -> seconds+1 and state=01.
- Assert reset during SET_MIN with minutes=37 -> immediate 12:00:00 AM, state=00.
